// File: rtl/skid_stage.sv
// skid_stage: elastic two-entry valid/ready pipeline stage.
// OutData comes straight from the head register. InReady depends only on
// the held state and Flush, so no combinational path runs from OutReady
// to InReady. A synchronous Flush empties the stage.
module skid_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // Handshake qualification and state-derived outputs
  always_comb begin
    OutValid  = (state != EMPTY);
    InReady   = (state != FULL) && !Flush;
    OutData   = main_q;
    in_fire   = InValid && InReady;
    out_fire  = OutValid && OutReady && !Flush;
    unique case (state)
      ONE:     Occupancy = 2'd1;
      FULL:    Occupancy = 2'd2;
      default: Occupancy = 2'd0;
    endcase
  end

  // Occupancy state and data registers. A flush clears validity only and
  // leaves the data registers unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (Flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= InData;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= InData;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= InData;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_skid_stage.sv
// tb_skid_stage: directed and random checks for skid_stage.
module tb_skid_stage;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             resetn;
  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic [1:0]       Occupancy;

  int errors;
  int checks;

  skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .Flush     (Flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .InData    (InData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutData   (OutData),
    .Occupancy (Occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic r,
                            input logic [1:0] occ, input logic [63:0] d);
    check({tag, ".OutValid"}, 64'(OutValid), 64'(v));
    check({tag, ".InReady"}, 64'(InReady), 64'(r));
    check({tag, ".Occupancy"}, 64'(Occupancy), 64'(occ));
    check({tag, ".OutData"}, OutData, d);
  endtask

  logic [63:0] q[$];
  bit          pend;

  initial begin
    errors   = 0;
    checks   = 0;
    resetn   = 1'b0;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    InData   = '0;

    // Reset held with random inputs; Flush kept low so InReady reads 1
    for (int i = 0; i < 4; i++) begin
      InValid  = 1'($urandom);
      OutReady = 1'($urandom);
      InData   = {$urandom, $urandom};
      step();
      check_outs("reset", 1'b0, 1'b1, 2'd0, 64'd0);
    end
    InValid = 1'b0;
    OutReady = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_outs("post_reset", 1'b0, 1'b1, 2'd0, 64'd0);

    // Streaming at full rate: output trails input by one cycle
    OutReady = 1'b1;
    InValid  = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      InData = 64'(i);
      step();
      check_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 64'(i));
    end
    InValid = 1'b0;
    step();
    check_outs("stream_drain", 1'b0, 1'b1, 2'd0, 64'd100);

    // Backpressure fills both entries; C waits upstream
    OutReady = 1'b0;
    InValid  = 1'b1;
    InData   = 64'hA;
    step();
    check_outs("bp_a", 1'b1, 1'b1, 2'd1, 64'hA);
    InData = 64'hB;
    step();
    check_outs("bp_full", 1'b1, 1'b0, 2'd2, 64'hA);
    InData = 64'hC;
    step();
    check_outs("bp_hold", 1'b1, 1'b0, 2'd2, 64'hA);
    OutReady = 1'b1;
    step();
    check_outs("bp_b", 1'b1, 1'b1, 2'd1, 64'hB);
    step();
    check_outs("bp_c", 1'b1, 1'b1, 2'd1, 64'hC);
    InValid = 1'b0;
    step();
    check_outs("bp_empty", 1'b0, 1'b1, 2'd0, 64'hC);

    // Flush while FULL with a pending input D
    OutReady = 1'b0;
    InValid  = 1'b1;
    InData   = 64'hA;
    step();
    InData = 64'hB;
    step();
    check_outs("fl_full", 1'b1, 1'b0, 2'd2, 64'hA);
    Flush  = 1'b1;
    InData = 64'hD;
    OutReady = 1'b1;
    #1;
    check("fl_inready_low", 64'(InReady), 64'd0);
    step();
    Flush   = 1'b0;
    InValid = 1'b0;
    #1;
    check_outs("fl_after", 1'b0, 1'b1, 2'd0, 64'hA);
    step();
    step();
    check_outs("fl_nodeliver", 1'b0, 1'b1, 2'd0, 64'hA);

    // Asynchronous reset while FULL, between edges
    OutReady = 1'b0;
    InValid  = 1'b1;
    InData   = 64'h11;
    step();
    InData = 64'h22;
    step();
    check_outs("ar_full", 1'b1, 1'b0, 2'd2, 64'h11);
    InValid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_outs("ar_immediate", 1'b0, 1'b1, 2'd0, 64'd0);
    @(negedge clk);
    resetn   = 1'b1;
    OutReady = 1'b1;
    step();
    step();
    check_outs("ar_after", 1'b0, 1'b1, 2'd0, 64'd0);

    // Random stress against a queue model; unaccepted input is held
    q.delete();
    pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      bit inf;
      bit outf;
      if (!pend) begin
        InValid = ($urandom_range(0, 3) != 0);
        InData  = {$urandom, $urandom};
      end
      OutReady = ($urandom_range(0, 2) != 0);
      Flush    = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      check("rnd.OutValid", 64'(OutValid), 64'(q.size() != 0));
      check("rnd.Occupancy", 64'(Occupancy), 64'(q.size()));
      check("rnd.InReady", 64'(InReady), 64'((q.size() < 2) && !Flush));
      if (q.size() != 0) check("rnd.OutData", OutData, q[0]);
      inf  = InValid && (q.size() < 2) && !Flush;
      outf = (q.size() != 0) && OutReady && !Flush;
      @(posedge clk);
      if (Flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(InData);
      end
      pend = InValid && !inf;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
